// File: rtl/leaves_mem_loader_pkg.sv
// Shared definitions for the leaves memory loader and the leaves memory it feeds.
// Holds the loader state encoding and the address/word width helpers.
// No logic of its own; widths follow the loader's default geometry.
package leaves_mem_loader_pkg;

    // Loader control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_t;

    // Bits needed to count 0..n-1, never less than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One memory word: patch index on top of the packed patch elements
    function automatic int wleaf_width(input int patch_size, input int data_width, input int idx_width);
        return patch_size * data_width + idx_width;
    endfunction

    // Default geometry: 64 leaves of 8 patches, 5 x 11-bit elements plus a 9-bit index
    localparam int LEAF_ADDRW  = cnt_width(64);
    localparam int WLEAF_WIDTH = wleaf_width(5, 11, 9);

endpackage

// File: rtl/leaves_mem_loader.sv
// Streams NUM_LEAVES*LEAF_SIZE patches into the banked leaves memory, one bank per slot.
// Latency: an accepted beat appears on the memory write port one cycle later.
// Backpressure: in_ready is high for the whole load; an in_valid gap simply skips a write.
module leaves_mem_loader
    import leaves_mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int IDX_WIDTH  = 9,
    parameter int LEAF_SIZE  = 8,
    parameter int PATCH_SIZE = 5,
    parameter int NUM_LEAVES = 64
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    start,
    output logic                                                    busy,
    output logic                                                    done,
    input  logic                                                    in_valid,
    output logic                                                    in_ready,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0]                        in_patch,
    input  logic [IDX_WIDTH-1:0]                                    in_idx,
    output logic [LEAF_SIZE-1:0]                                    csb0,
    output logic [LEAF_SIZE-1:0]                                    web0,
    output logic [cnt_width(NUM_LEAVES)-1:0]                        addr0,
    output logic [wleaf_width(PATCH_SIZE, DATA_WIDTH, IDX_WIDTH)-1:0] wleaf0
);

    localparam int ADDR_W = cnt_width(NUM_LEAVES);
    localparam int SLOT_W = cnt_width(LEAF_SIZE);

    localparam logic [SLOT_W-1:0]    SLOT_LAST = SLOT_W'(LEAF_SIZE - 1);
    localparam logic [ADDR_W-1:0]    LEAF_LAST = ADDR_W'(NUM_LEAVES - 1);
    localparam logic [LEAF_SIZE-1:0] BANK0_SEL = LEAF_SIZE'(1);

    ld_state_t           state_q;
    ld_state_t           state_d;
    logic [SLOT_W-1:0]   slot_q;
    logic [ADDR_W-1:0]   leaf_q;
    logic                accept;
    logic                last_beat;

    assign in_ready  = (state_q == ST_LOAD);
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (slot_q == SLOT_LAST) && (leaf_q == LEAF_LAST);

    // busy covers DONE so it stays up while the final write is on the port
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only matters in IDLE, DONE lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_LOAD;
            ST_LOAD: if (last_beat) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Slot/leaf counters: cleared on entering LOAD, advanced per accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            leaf_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            slot_q <= '0;
            leaf_q <= '0;
        end else if (accept) begin
            if (slot_q == SLOT_LAST) begin
                slot_q <= '0;
                leaf_q <= (leaf_q == LEAF_LAST) ? '0 : leaf_q + 1'b1;
            end else begin
                slot_q <= slot_q + 1'b1;
            end
        end
    end

    // Registered memory write port; address and data hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb0   <= '1;
            web0   <= '1;
            addr0  <= '0;
            wleaf0 <= '0;
        end else begin
            csb0 <= '1;
            web0 <= '1;
            if (accept) begin
                csb0   <= ~(BANK0_SEL << slot_q);
                web0   <= ~(BANK0_SEL << slot_q);
                addr0  <= leaf_q;
                wleaf0 <= {in_idx, in_patch};
            end
        end
    end

endmodule

// File: tb/tb_leaves_mem_loader.sv
// Bench for leaves_mem_loader: scoreboard of expected writes plus per-scenario tasks.
// Expected writes are queued at acceptance and compared one cycle later.
// Inputs are driven 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_leaves_mem_loader;
    import leaves_mem_loader_pkg::*;

    localparam int DW    = 11;
    localparam int IW    = 9;
    localparam int LS    = 8;
    localparam int PS    = 5;
    localparam int NL    = 64;
    localparam int PW    = PS * DW;
    localparam int AW    = LEAF_ADDRW;
    localparam int WW    = WLEAF_WIDTH;
    localparam int TOTAL = NL * LS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_patch = '0;
    logic [IW-1:0] in_idx = '0;
    logic [LS-1:0] csb0;
    logic [LS-1:0] web0;
    logic [AW-1:0] addr0;
    logic [WW-1:0] wleaf0;

    leaves_mem_loader #(
        .DATA_WIDTH(DW), .IDX_WIDTH(IW), .LEAF_SIZE(LS), .PATCH_SIZE(PS), .NUM_LEAVES(NL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_patch(in_patch), .in_idx(in_idx),
        .csb0(csb0), .web0(web0), .addr0(addr0), .wleaf0(wleaf0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LS-1:0] csb;
        logic [AW-1:0] addr;
        logic [WW-1:0] wleaf;
        int            bank;
    } exp_t;

    typedef enum {M_IDLE, M_LOAD, M_DONE} mstate_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    exp_t          new_e;
    int            checks = 0;
    int            passed = 0;
    mstate_t       mstate = M_IDLE;
    int            k = 0;
    bit            exp_done = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [WW-1:0] last_wleaf = '0;
    int            writes = 0;
    int            done_cnt = 0;
    logic [AW-1:0] done_addr = '0;
    logic [LS-1:0] done_csb = '0;
    bit            written[NL][LS];

    // Scoreboard and behavioural model, evaluated once per cycle on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            mstate = M_IDLE;
            k = 0;
            exp_done = 1'b0;
            sb_q.delete();
            last_addr = '0;
            last_wleaf = '0;
        end else begin
            if (csb0 !== {LS{1'b1}}) begin
                checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL unexpected_write: csb0=%h addr0=%0d, want no write", csb0, addr0);
                end else begin
                    passed++;
                    mon_e = sb_q.pop_front();
                    checks++;
                    if (csb0 !== mon_e.csb) $display("FAIL wr_csb0: got %h want %h", csb0, mon_e.csb);
                    else passed++;
                    checks++;
                    if (web0 !== mon_e.csb) $display("FAIL wr_web0: got %h want %h", web0, mon_e.csb);
                    else passed++;
                    checks++;
                    if (addr0 !== mon_e.addr) $display("FAIL wr_addr0: got %0d want %0d", addr0, mon_e.addr);
                    else passed++;
                    checks++;
                    if (wleaf0 !== mon_e.wleaf) $display("FAIL wr_wleaf0: got %h want %h", wleaf0, mon_e.wleaf);
                    else passed++;
                    checks++;
                    if (written[mon_e.addr][mon_e.bank]) $display("FAIL dup_write: addr %0d bank %0d written twice", mon_e.addr, mon_e.bank);
                    else passed++;
                    written[mon_e.addr][mon_e.bank] = 1'b1;
                    writes++;
                    last_addr = mon_e.addr;
                    last_wleaf = mon_e.wleaf;
                end
            end else begin
                if (sb_q.size() != 0) begin
                    checks++;
                    mon_e = sb_q.pop_front();
                    $display("FAIL missing_write: csb0=%h want %h", csb0, mon_e.csb);
                end
                checks++;
                if (web0 !== {LS{1'b1}}) $display("FAIL idle_web0: got %h want all ones", web0);
                else passed++;
                checks++;
                if (addr0 !== last_addr) $display("FAIL hold_addr0: got %0d want %0d", addr0, last_addr);
                else passed++;
                checks++;
                if (wleaf0 !== last_wleaf) $display("FAIL hold_wleaf0: got %h want %h", wleaf0, last_wleaf);
                else passed++;
            end
            checks++;
            if (done !== exp_done) $display("FAIL done: got %b want %b", done, exp_done);
            else passed++;
            checks++;
            if (busy !== (mstate != M_IDLE)) $display("FAIL busy: got %b want %b", busy, mstate != M_IDLE);
            else passed++;
            checks++;
            if (in_ready !== (mstate == M_LOAD)) $display("FAIL in_ready: got %b want %b", in_ready, mstate == M_LOAD);
            else passed++;
            if (done === 1'b1) begin
                done_cnt++;
                done_addr = addr0;
                done_csb = csb0;
            end
            exp_done = 1'b0;
            case (mstate)
                M_IDLE: if (start) begin
                    mstate = M_LOAD;
                    k = 0;
                end
                M_LOAD: if (in_valid) begin
                    new_e.csb   = ~(LS'(1) << (k % LS));
                    new_e.addr  = AW'(k / LS);
                    new_e.wleaf = {in_idx, in_patch};
                    new_e.bank  = k % LS;
                    sb_q.push_back(new_e);
                    if (k == TOTAL - 1) begin
                        mstate = M_DONE;
                        exp_done = 1'b1;
                    end
                    k++;
                end
                M_DONE: mstate = M_IDLE;
                default: mstate = M_IDLE;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [PW-1:0] rand_patch();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[PW-1:0];
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Presents one beat and returns 1ns after the edge that accepted it
    task automatic send_beat(input logic [IW-1:0] idx, input logic [PW-1:0] patch);
        bit acc;
        acc = 1'b0;
        in_idx = idx;
        in_patch = patch;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            $display("FAIL send_beat_timeout: in_ready never seen, want 1");
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (csb0 !== 8'hFF) $display("FAIL rst_csb0: got %h want ff", csb0); else passed++;
        checks++; if (web0 !== 8'hFF) $display("FAIL rst_web0: got %h want ff", web0); else passed++;
        checks++; if (addr0 !== '0) $display("FAIL rst_addr0: got %0d want 0", addr0); else passed++;
        checks++; if (wleaf0 !== '0) $display("FAIL rst_wleaf0: got %h want 0", wleaf0); else passed++;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL rst_ctrl: busy=%b done=%b in_ready=%b want 0 0 0", busy, done, in_ready);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL idle_in_ready: got %b want 0", in_ready); else passed++;
    endtask

    task automatic test_single_beat();
        logic [WW-1:0] exp_w;
        exp_w = {9'h1A5, 55'h1};
        do_start();
        send_beat(9'h1A5, 55'h1);
        checks++; if (csb0 !== 8'hFE) $display("FAIL single_csb0: got %h want fe", csb0); else passed++;
        checks++; if (web0 !== 8'hFE) $display("FAIL single_web0: got %h want fe", web0); else passed++;
        checks++; if (addr0 !== 6'd0) $display("FAIL single_addr0: got %0d want 0", addr0); else passed++;
        checks++; if (wleaf0 !== exp_w) $display("FAIL single_wleaf0: got %h want %h", wleaf0, exp_w); else passed++;
    endtask

    // Beats 1..8 back-to-back, continuing the load opened by the single-beat test
    task automatic test_bank_wrap();
        for (int b = 1; b <= 8; b++) begin
            send_beat(IW'($urandom()), rand_patch());
            if (b == 7) begin
                checks++; if (csb0 !== 8'h7F || addr0 !== 6'd0)
                    $display("FAIL wrap_beat7: csb0=%h addr0=%0d want 7f 0", csb0, addr0);
                else passed++;
            end
            if (b == 8) begin
                checks++; if (csb0 !== 8'hFE || addr0 !== 6'd1)
                    $display("FAIL wrap_beat8: csb0=%h addr0=%0d want fe 1", csb0, addr0);
                else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        int w0;
        for (int b = 9; b <= 11; b++) send_beat(IW'($urandom()), rand_patch());
        @(posedge clk);
        #1;
        w0 = writes;
        for (int i = 0; i < 5; i++) begin
            checks++; if (csb0 !== 8'hFF || web0 !== 8'hFF)
                $display("FAIL gap_strobe: csb0=%h web0=%h want ff ff", csb0, web0);
            else passed++;
            @(posedge clk);
            #1;
        end
        checks++; if (writes !== w0) $display("FAIL gap_writes: got %0d want %0d", writes, w0); else passed++;
        send_beat(IW'($urandom()), rand_patch());
        checks++; if (csb0 !== 8'hEF || addr0 !== 6'd1)
            $display("FAIL gap_resume: csb0=%h addr0=%0d want ef 1", csb0, addr0);
        else passed++;
    endtask

    task automatic test_start_ignored();
        for (int b = 13; b <= 19; b++) send_beat(IW'($urandom()), rand_patch());
        start = 1'b1;
        send_beat(IW'($urandom()), rand_patch());
        start = 1'b0;
        checks++; if (csb0 !== 8'hEF || addr0 !== 6'd2)
            $display("FAIL start_beat20: csb0=%h addr0=%0d want ef 2", csb0, addr0);
        else passed++;
        send_beat(IW'($urandom()), rand_patch());
        checks++; if (csb0 !== 8'hDF || addr0 !== 6'd2)
            $display("FAIL start_beat21: csb0=%h addr0=%0d want df 2", csb0, addr0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        for (int b = 22; b <= 100; b++) send_beat(IW'($urandom()), rand_patch());
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (csb0 !== 8'hFF || web0 !== 8'hFF)
            $display("FAIL midrst_strobe: csb0=%h web0=%h want ff ff", csb0, web0);
        else passed++;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL midrst_ctrl: in_ready=%b busy=%b want 0 0", in_ready, busy);
        else passed++;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_start();
        send_beat(IW'($urandom()), rand_patch());
        checks++; if (csb0 !== 8'hFE || addr0 !== 6'd0)
            $display("FAIL midrst_restart: csb0=%h addr0=%0d want fe 0", csb0, addr0);
        else passed++;
    endtask

    task automatic test_full_load();
        int cov;
        pulse_reset();
        foreach (written[a, b]) written[a][b] = 1'b0;
        writes = 0;
        done_cnt = 0;
        do_start();
        for (int b = 0; b < TOTAL; b++) begin
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(3, 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(IW'($urandom()), rand_patch());
        end
        checks++; if (done !== 1'b1 || busy !== 1'b1)
            $display("FAIL full_done: done=%b busy=%b want 1 1", done, busy);
        else passed++;
        checks++; if (addr0 !== 6'd63 || csb0 !== 8'h7F)
            $display("FAIL full_last: addr0=%0d csb0=%h want 63 7f", addr0, csb0);
        else passed++;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL full_after: busy=%b done=%b want 0 0", busy, done);
        else passed++;
        @(negedge clk);
        @(posedge clk);
        #1;
        cov = 0;
        foreach (written[a, b]) if (written[a][b]) cov++;
        checks++; if (writes !== TOTAL) $display("FAIL full_writes: got %0d want %0d", writes, TOTAL); else passed++;
        checks++; if (cov !== TOTAL) $display("FAIL full_cover: got %0d want %0d", cov, TOTAL); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL full_done_cnt: got %0d want 1", done_cnt); else passed++;
        checks++; if (done_addr !== 6'd63 || done_csb !== 8'h7F)
            $display("FAIL full_done_write: addr0=%0d csb0=%h want 63 7f", done_addr, done_csb);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_bank_wrap();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_full_load();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
